// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
// Holds the access size codes, the exception codes, the FSM state encodings
// and the alignment check that the top level uses.
package mem_pkg;

  // Access size codes: log2 of the number of bytes moved.
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Exception codes reported to WB.
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [1:0] EXC_ILLSIZE  = 2'd3;

  // FSM state encodings.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // An access is misaligned when any address bit below its size is set.
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] m;
    m = (3'd1 << size) - 3'd1;
    return |(addr_lo & m);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for one bus beat (purely combinational).
// Ports:
//   size_i      log2 of access bytes
//   lane_i      byte offset of the access within the bus word
//   ext_i       1 = sign-extend load data, 0 = zero-extend
//   wdata_i     right-aligned store data
//   rdata_i     raw read data from the bus
//   be_o        byte enables for the access
//   wdata_sh_o  store data moved onto its byte lanes
//   rdata_ext_o load data moved down, masked to the access size and extended
module mem_lane_align #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int LANE_W     = $clog2(SEL_WIDTH)
) (
  input  logic [1:0]            size_i,
  input  logic [LANE_W-1:0]     lane_i,
  input  logic                  ext_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [SEL_WIDTH-1:0]  be_o,
  output logic [DATA_WIDTH-1:0] wdata_sh_o,
  output logic [DATA_WIDTH-1:0] rdata_ext_o
);

  logic [LANE_W+2:0]     shamt;
  logic [15:0]           be_full;
  logic [6:0]            nbits;
  logic [DATA_WIDTH-1:0] sh, m, msb;

  always_comb begin
    shamt      = {lane_i, 3'b000};
    // 2^size ones, then moved up to the lane; aligned accesses never spill past SEL_WIDTH.
    be_full    = ((16'd1 << (5'd1 << size_i)) - 16'd1) << lane_i;
    be_o       = be_full[SEL_WIDTH-1:0];
    wdata_sh_o = wdata_i << shamt;
    sh         = rdata_i >> shamt;
    nbits      = 7'd8 << size_i;
    // Full-width accesses keep every bit; narrower ones are masked.
    m = '1;
    if (nbits < 7'(DATA_WIDTH)) m = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
    // Top bit of the mask marks the sign bit of the loaded value.
    msb         = m ^ (m >> 1);
    rdata_ext_o = (sh & m) | ((ext_i && |(sh & msb)) ? ~m : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access stage between EX and WB.
// Takes one load/store/pass-through op per handshake, runs it on a
// req/gnt/rvalid RAM port with a cycle budget, and hands a registered result
// to WB as a one-cycle out_valid pulse.
// Ports:
//   clk, rst                          clock, async active-high reset
//   in_valid/in_ready                 op handshake from EX
//   in_read/in_write/in_ext/in_size   op kind, extension, access size
//   in_addr/in_wdata                  effective address, right-aligned store data
//   in_rd_en/in_rd_addr/in_pc         writeback control carried through
//   ram_req/ram_gnt/ram_we/ram_addr/ram_wdata/ram_rvalid/ram_rdata  RAM port
//   load_busy                         load in flight, to ID
//   out_valid/out_result/out_rd_en/out_rd_addr/out_pc/out_exc       to WB
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_read,
  input  logic                  in_write,
  input  logic                  in_ext,
  input  logic [1:0]            in_size,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  in_rd_en,
  input  logic [4:0]            in_rd_addr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  ram_req,
  input  logic                  ram_gnt,
  output logic [SEL_WIDTH-1:0]  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_rvalid,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  load_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_rd_en,
  output logic [4:0]            out_rd_addr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [1:0]            out_exc
);

  localparam int LANE_W = $clog2(SEL_WIDTH);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            exc_q, exc_d;
  logic                  read_q, write_q, ext_q, rd_en_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q, pc_q;
  logic [DATA_WIDTH-1:0] wdata_q, res_q;
  logic [4:0]            rd_addr_q;
  logic                  out_valid_q, out_rd_en_q;
  logic [DATA_WIDTH-1:0] out_result_q;
  logic [4:0]            out_rd_addr_q;
  logic [ADDR_WIDTH-1:0] out_pc_q;
  logic [1:0]            out_exc_q;
  logic [SEL_WIDTH-1:0]  be;
  logic [DATA_WIDTH-1:0] wdata_sh, ld_data;
  logic                  to_hit;

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size_i      (size_q),
    .lane_i      (addr_q[LANE_W-1:0]),
    .ext_i       (ext_q),
    .wdata_i     (wdata_q),
    .rdata_i     (ram_rdata),
    .be_o        (be),
    .wdata_sh_o  (wdata_sh),
    .rdata_ext_o (ld_data)
  );

  // Last budgeted cycle in REQ/WAIT; a gnt or rvalid in that same cycle still completes.
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        cnt_d   = '0;
        exc_d   = EXC_NONE;
        state_d = S_REQ;
        if (!(in_read || in_write)) state_d = S_DONE;
        else if (in_size > 2'(LANE_W)) begin
          state_d = S_DONE;
          exc_d   = EXC_ILLSIZE;
        end else if (misaligned(in_addr[2:0], in_size)) begin
          state_d = S_DONE;
          exc_d   = EXC_MISALIGN;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_gnt) state_d = read_q ? S_WAIT : S_DONE;
        else if (to_hit) begin
          state_d = S_DONE;
          exc_d   = EXC_TIMEOUT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_rvalid) state_d = S_DONE;
        else if (to_hit) begin
          state_d = S_DONE;
          exc_d   = EXC_TIMEOUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      exc_q         <= EXC_NONE;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      ext_q         <= 1'b0;
      size_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      pc_q          <= '0;
      res_q         <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_en_q   <= 1'b0;
      out_rd_addr_q <= '0;
      out_pc_q      <= '0;
      out_exc_q     <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      if (state_q == S_IDLE && in_valid) begin
        read_q    <= in_read;
        write_q   <= in_write;
        ext_q     <= in_ext;
        size_q    <= in_size;
        addr_q    <= in_addr;
        wdata_q   <= in_wdata;
        rd_en_q   <= in_rd_en;
        rd_addr_q <= in_rd_addr;
        pc_q      <= in_pc;
        // Non-loads return the address; a completing load overwrites it below.
        res_q     <= DATA_WIDTH'(in_addr);
      end
      if (state_q == S_WAIT && ram_rvalid) res_q <= ld_data;
      out_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        out_result_q  <= res_q;
        out_rd_en_q   <= rd_en_q && (exc_q == EXC_NONE);
        out_rd_addr_q <= rd_addr_q;
        out_pc_q      <= pc_q;
        out_exc_q     <= exc_q;
      end
    end
  end

  // RAM-side outputs are gated to REQ so they read zero whenever no request is up.
  assign in_ready    = (state_q == S_IDLE);
  assign ram_req     = (state_q == S_REQ);
  assign ram_we      = (ram_req && !read_q) ? be : '0;
  assign ram_addr    = ram_req ? {addr_q[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign ram_wdata   = ram_req ? wdata_sh : '0;
  assign load_busy   = read_q && (state_q == S_REQ || state_q == S_WAIT);
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd_en   = out_rd_en_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_pc      = out_pc_q;
  assign out_exc     = out_exc_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, multi-cycle successor to the pipeline MEM stage.
- Accepts one load/store/pass-through op per handshake from EX and drives a request/grant/rvalid RAM port that may stall.
- Aligns store lanes, extracts and extends load data, and detects misalignment, illegal size and bus timeout.
- Delivers a registered result to WB and a busy/load-hazard flag to ID.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- SEL_WIDTH, DATA_WIDTH/8, byte-enable width (derived, do not override).
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+WAIT before the op aborts; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  op offered by EX
- in_ready  out  1  unit can accept an op; equals state==IDLE
- in_read, in_write  in  1 each  load / store; both 0 = pass-through
- in_ext  in  1  load sign-extend (1) / zero-extend (0)
- in_size  in  2  log2 of access bytes: 0=byte, 1=half, 2=word, 3=dword
- in_addr  in  ADDR_WIDTH  effective address; also the ALU result
- in_wdata  in  DATA_WIDTH  store data, right-aligned
- in_rd_en, in_rd_addr, in_pc  in  1/5/ADDR_WIDTH  writeback control, carried through
- ram_req  out  1  RAM request, held until granted
- ram_gnt  in  1  request accepted this cycle
- ram_we  out  SEL_WIDTH  byte write enables; 0 for loads
- ram_addr  out  ADDR_WIDTH  address with low log2(SEL_WIDTH) bits cleared
- ram_wdata  out  DATA_WIDTH  lane-shifted store data
- ram_rvalid, ram_rdata  in  1/DATA_WIDTH  read data return
- load_busy  out  1  to ID; 1 whenever a load is in flight (REQ/WAIT with read)
- out_valid  out  1  one-cycle pulse to WB
- out_result  out  DATA_WIDTH  extended load data, or in_addr zero-extended for non-loads
- out_rd_en, out_rd_addr, out_pc  out  1/5/ADDR_WIDTH  writeback control
- out_exc  out  2  exception code: 0 none, 1 misaligned, 2 timeout, 3 illegal size

Behaviour:
Reset:
- Every output 0 except in_ready=1; state IDLE; timeout counter 0.
- Reset asserted mid-operation aborts at once, drops ram_req and emits no out_valid.

State machine: IDLE, REQ, WAIT, DONE.
- IDLE: accept when in_valid (in_ready=1) and latch all inputs.
  - Pass-through, misaligned (addr mod 2^size ≠ 0) or illegal (size > log2(SEL_WIDTH)) → DONE. No RAM access. On an exception out_rd_en is forced to 0.
  - Otherwise → REQ.
- REQ: ram_req=1 with ram_addr, ram_we and ram_wdata stable.
  - On ram_gnt: a store → DONE; a load → WAIT.
- WAIT: a load waits for ram_rvalid, which is never sampled in the cycle of gnt. On rvalid, capture and extend the data → DONE.
- DONE: out_valid=1 for exactly one cycle, then → IDLE. The out_* signals hold until the next DONE.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: → DONE with out_exc=2, out_rd_en=0, ram_req dropped.
  - A stray rvalid while not in WAIT is ignored.

Latency:
- Pass-through and exceptions: out_valid 2 cycles after acceptance.
- Store with immediate gnt: 3 cycles.
- Load: 3 cycles + gnt wait + rvalid wait.

Lanes:
- lane = addr[log2(SEL_WIDTH)-1:0].
- ram_we = ((1<<2^size)-1) << lane.
- ram_wdata = in_wdata << 8·lane.
- load: data = ram_rdata >> 8·lane, masked to 8·2^size bits, then sign- or zero-extended per in_ext.
- Word and dword use the full bus width; no masking is needed when 2^size == SEL_WIDTH.

Decomposition:
- Shared package/header mem_pkg:
  - size codes SZ_BYTE..SZ_DWORD
  - exception codes EXC_NONE/MISALIGN/TIMEOUT/ILLSIZE
  - FSM state encodings
- Sub-module mem_lane_align: purely combinational. Produces byte enables, store shift and load extract/extend from size, lane and ext. It is reused by a future I-cache refill path.

Test Plan:
- DATA_WIDTH=32. Store byte: addr=0x1003, wdata=0xAB, gnt immediate → ram_we=1000, ram_wdata=0xAB000000, ram_addr=0x1000. out_valid 3 cycles after accept, out_exc=0.
- Load half signed: addr=0x2002, rdata=0x8001_1234, rvalid 2 cycles after gnt → out_result=0xFFFF8001. With in_ext=0 → 0x00008001. load_busy=1 throughout REQ/WAIT.
- Misaligned word load: addr=0x0006 → ram_req never asserted, out_exc=1, out_rd_en=0. Illegal size 3 at DATA_WIDTH=32 → out_exc=3.
- Timeout: ram_gnt held 0 for 16 cycles → ram_req deasserts, out_exc=2, in_ready returns to 1. A late rvalid afterwards produces no out_valid.
- DATA_WIDTH=64. Dword store at 0x08 → ram_we=0xFF. Word load at 0x0C with rdata upper half 0x7FFFFFFF, in_ext=1 → out_result=0x000000007FFFFFFF.
- Async reset asserted during WAIT → all outputs 0 before the next clock edge, then a fresh pass-through op (addr=0x55) → out_result=0x55.
